// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch address and advances it by increment, jump or call/return.
// Latency: the new pc is visible the cycle after fire (pc_valid & pc_ready); back-to-back fires give one address per cycle.
// Backpressure: while pc_ready is low, pc and pc_valid hold and jump/call/ret/halt are ignored.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   jump, jump_addr      on fire, load jump_addr (jump_addr comes from the 2:1 target mux)
//   call, ret            on fire, push pc+1 and jump / pop into pc (PC_STACK_EN builds only)
//   halt                 on fire, stop presenting addresses after this one
//   pc, pc_valid         fetch address and its valid flag
//   pc_ready             fetch stage accepts pc this cycle
//   stack_err            sticky return-stack overflow/underflow flag
//
// Build option: define PC_STACK_EN to build the return stack. Without it, call and ret
// are ignored and stack_err is tied 0.
module pc_sequencer #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_ADDR  = '0,
  parameter int               STACK_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             call,
  input  logic             ret,
  input  logic             halt,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  input  logic             pc_ready,
  output logic             stack_err
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] PC_ONE = 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pc_inc;
  logic             fire;

  // pc_valid is a pure function of the state register, so it never glitches
  // and cannot be withdrawn between cycles unless a fire moved the FSM.
  assign pc_valid = (state == ST_RUN);
  assign fire     = pc_valid & pc_ready;
  assign pc_inc   = pc + PC_ONE;   // wraps modulo 2**WIDTH

`ifdef PC_STACK_EN
  localparam int             SPW     = $clog2(STACK_DEPTH);
  localparam logic [SPW:0]   SP_ONE  = 1;
  localparam logic [SPW:0]   SP_FULL = (SPW+1)'(STACK_DEPTH);
  localparam logic [SPW-1:0] IDX_ONE = 1;

  logic [WIDTH-1:0] stack [STACK_DEPTH];
  logic [SPW:0]     sp, sp_nxt;       // number of live entries, 0..STACK_DEPTH
  logic [SPW-1:0]   wr_idx, top_idx;
  logic             err, err_nxt;
  logic             push;

  assign wr_idx    = sp[SPW-1:0];
  assign top_idx   = wr_idx - IDX_ONE;
  assign stack_err = err;
`else
  // call/ret and the depth setting have no function in this build.
  logic unused_stack_ins;
  assign unused_stack_ins = call | ret | (STACK_DEPTH == 0);
  assign stack_err        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
`ifdef PC_STACK_EN
    sp_nxt    = sp;
    err_nxt   = err;
    push      = 1'b0;
`endif
    case (state)
      ST_RESET: state_nxt = ST_RUN;
      ST_RUN: begin
        if (fire) begin
          // The accepted address still advances when halting.
          if (halt) state_nxt = ST_HALTED;
`ifdef PC_STACK_EN
          if (ret) begin
            if (sp != '0) begin
              pc_nxt = stack[top_idx];
              sp_nxt = sp - SP_ONE;
            end else begin
              pc_nxt  = pc_inc;
              err_nxt = 1'b1;
            end
          end else if (call) begin
            // A call into a full stack still jumps; only the push is lost.
            pc_nxt = jump_addr;
            if (sp != SP_FULL) begin
              push   = 1'b1;
              sp_nxt = sp + SP_ONE;
            end else begin
              err_nxt = 1'b1;
            end
          end else
`endif
          if (jump) pc_nxt = jump_addr;
          else      pc_nxt = pc_inc;
        end
      end
      ST_HALTED: if (!halt) state_nxt = ST_RUN;
      default:   state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
      pc    <= RESET_ADDR;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

`ifdef PC_STACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      err <= 1'b0;
    end else begin
      sp  <= sp_nxt;
      err <= err_nxt;
    end
  end

  // Storage needs no reset: entries are only read below the pointer.
  always_ff @(posedge clk) begin
    if (push) stack[wr_idx] <= pc_inc;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump, call, ret, halt, pc_ready;
  logic [15:0] jump_addr;
  logic [15:0] pc;
  logic        pc_valid, stack_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural view only.
  logic [15:0] m_pc;
  bit          m_valid;
  bit          m_started;   // first edge after reset release seen
  bit          m_err;
  logic [15:0] m_stk[$];

  pc_sequencer #(.WIDTH(16), .RESET_ADDR(16'h0000), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .jump(jump), .jump_addr(jump_addr),
    .call(call), .ret(ret), .halt(halt), .pc(pc), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_valid = 0; m_started = 0; m_err = 0;
    m_stk.delete();
  endtask

  task automatic model_edge(input bit j, input logic [15:0] ja, input bit c,
                            input bit r, input bit h, input bit rdy);
    bit stack_on;
`ifdef PC_STACK_EN
    stack_on = 1;
`else
    stack_on = 0;
`endif
    if (!m_started) begin
      m_started = 1;
      m_valid   = 1;
    end else if (m_valid) begin
      if (rdy) begin
        if (stack_on && r) begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin m_err = 1; m_pc = m_pc + 16'd1; end
        end else if (stack_on && c) begin
          if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 16'd1);
          else m_err = 1;
          m_pc = ja;
        end else if (j) m_pc = ja;
        else m_pc = m_pc + 16'd1;
        if (h) m_valid = 0;
      end
    end else if (!h) begin
      m_valid = 1;
    end
  endtask

  // Drive inputs (called away from posedge), take one clock, compare at negedge.
  task automatic step(input bit j, input logic [15:0] ja, input bit c,
                      input bit r, input bit h, input bit rdy);
    jump = j; jump_addr = ja; call = c; ret = r; halt = h; pc_ready = rdy;
    @(posedge clk);
    model_edge(j, ja, c, r, h, rdy);
    @(negedge clk);
    check("pc", {16'h0, pc}, {16'h0, m_pc});
    check("pc_valid", {31'h0, pc_valid}, {31'h0, m_valid});
    check("stack_err", {31'h0, stack_err}, {31'h0, m_err});
  endtask

  task automatic run(input bit rdy);   // plain increment step
    step(0, 16'h0, 0, 0, 0, rdy);
  endtask

  initial begin
    rst_n = 1'b0; jump = 0; call = 0; ret = 0; halt = 0; pc_ready = 0; jump_addr = '0;
    model_reset();
    #12;
    check("rst_pc", {16'h0, pc}, 32'h0);
    check("rst_vld", {31'h0, pc_valid}, 32'h0);
    check("rst_err", {31'h0, stack_err}, 32'h0);

    // Reset release with ready high: 0,1,2,3 on consecutive cycles.
    @(negedge clk);
    rst_n = 1'b1;
    pc_ready = 1'b1;
    #1 check("cycle0_vld", {31'h0, pc_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      run(1);
      check("seq", {16'h0, pc}, i);
    end

    // Backpressure at pc=5.
    run(1); run(1);
    check("pc5", {16'h0, pc}, 32'h5);
    for (int i = 0; i < 3; i++) run(0);
    check("bp_hold_pc", {16'h0, pc}, 32'h5);
    check("bp_hold_vld", {31'h0, pc_valid}, 32'h1);
    run(1);
    check("bp_release", {16'h0, pc}, 32'h6);

    // Jump at pc=7, first without ready.
    run(1);
    step(1, 16'h1234, 0, 0, 0, 0);
    check("jump_noready", {16'h0, pc}, 32'h7);
    step(1, 16'h1234, 0, 0, 0, 1);
    check("jump", {16'h0, pc}, 32'h1234);

    // Wrap.
    step(1, 16'hFFFF, 0, 0, 0, 1);
    run(1);
    check("wrap", {16'h0, pc}, 32'h0);

    // Halt at pc=9.
    step(1, 16'h0009, 0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 1, 1);
    check("halt_pc", {16'h0, pc}, 32'hA);
    check("halt_vld", {31'h0, pc_valid}, 32'h0);
    step(0, 16'h0, 0, 0, 1, 1);
    check("halted_hold", {16'h0, pc}, 32'hA);
    step(0, 16'h0, 0, 0, 0, 0);
    check("resume_vld", {31'h0, pc_valid}, 32'h1);
    check("resume_pc", {16'h0, pc}, 32'hA);

`ifdef PC_STACK_EN
    step(1, 16'h0020, 0, 0, 0, 1);
    step(0, 16'h0100, 1, 0, 0, 1);
    check("call", {16'h0, pc}, 32'h0100);
    step(0, 16'h0, 0, 1, 0, 1);
    check("ret", {16'h0, pc}, 32'h0021);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 16'h0200 + 16'(i * 16), 1, 0, 0, 1);
    check("overflow", {31'h0, stack_err}, 32'h1);
    for (int i = 0; i < DEPTH; i++) step(0, 16'h0, 0, 1, 0, 1);
    step(0, 16'h0, 0, 1, 0, 1);
    check("underflow_err", {31'h0, stack_err}, 32'h1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 4) == 0, 16'($urandom), $urandom_range(0, 6) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0);
    end

    // Async reset mid-backpressure at pc=0x42.
    step(0, 16'h0, 0, 0, 0, 0);          // leave HALTED if needed
    step(1, 16'h0042, 0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 0, 0);
    check("pre_rst_pc", {16'h0, pc}, 32'h42);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_pc", {16'h0, pc}, 32'h0);
    check("async_rst_vld", {31'h0, pc_valid}, 32'h0);
    check("async_rst_err", {31'h0, stack_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) run(1);
    check("post_rst_pc", {16'h0, pc}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
